// File: rtl/rt_mem_rb_pkg.sv
// Shared types for the port-B sequential readback engine.
// The FIFO entry layout pairs each returned word with its byte address.
package rt_mem_rb_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned RB_ADDR_W  = 22;
  localparam int unsigned RB_DATA_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_GAP,
    ST_FLUSH
  } rb_state_e;

  typedef struct packed {
    logic [RB_ADDR_W-1:0] addr;
    logic [RB_DATA_W-1:0] data;
  } rb_entry_t;

endpackage

// File: rtl/rt_mem_rb_fifo.sv
// Two-entry first-word-fall-through FIFO for readback words.
// Push while full is accepted only when a pop happens in the same cycle.
module rt_mem_rb_fifo
  import rt_mem_rb_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      flush_i,
  input  logic      push_i,
  input  rb_entry_t wdata_i,
  input  logic      pop_i,
  output rb_entry_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  rb_entry_t  mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/rt_mem_readback.sv
// Sequential single-word reader for dp_ram port B; streams {addr, data}
// through a 2-deep FWFT buffer and tolerates variable response latency.
module rt_mem_readback
  import rt_mem_rb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 22,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CNT_WIDTH      = 21,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  num_words_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  en_b_o,
  output logic                  we_b_o,
  output logic [3:0]            be_b_o,
  output logic [ADDR_WIDTH-1:0] addr_b_o,
  input  logic [DATA_WIDTH-1:0] rdata_b_i,
  input  logic                  rvalid_b_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  rb_state_e             state_q;
  rb_state_e             state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic [TMO_W-1:0]      tmo_q;
  logic                  error_q;

  logic      accept;
  logic      push;
  logic      flush;
  logic      timeout;
  logic      tmo_hit;
  logic      fifo_full;
  logic      fifo_empty;
  rb_entry_t push_entry;
  rb_entry_t head;

  logic unused_base_lsbs;
  assign unused_base_lsbs = ^base_addr_i[1:0];

  assign accept  = (state_q == ST_IDLE) && start_i;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Abort overrides everything, including a response arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    flush   = 1'b0;
    timeout = 1'b0;
    done_o  = 1'b0;
    if (state_q != ST_IDLE && abort_i) begin
      state_d = ST_IDLE;
      flush   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) state_d = (num_words_i == '0) ? ST_FLUSH : ST_REQ;
        end
        ST_REQ: state_d = ST_WAIT;
        ST_WAIT: begin
          if (rvalid_b_i) begin
            push    = 1'b1;
            state_d = ST_GAP;
          end else if (tmo_hit) begin
            timeout = 1'b1;
            flush   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_GAP: begin
          if (remaining_q == '0)  state_d = ST_FLUSH;
          else if (!fifo_full)    state_d = ST_REQ;
        end
        ST_FLUSH: begin
          if (fifo_empty) begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      tmo_q       <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q      <= {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
        remaining_q <= num_words_i;
        error_q     <= 1'b0;
      end
      if (state_q == ST_REQ)       tmo_q <= '0;
      else if (state_q == ST_WAIT) tmo_q <= tmo_q + 1'b1;
      if (push) begin
        addr_q      <= addr_q + ADDR_WIDTH'(WORD_BYTES);
        remaining_q <= remaining_q - 1'b1;
      end
      if (timeout) error_q <= 1'b1;
    end
  end

  assign push_entry.addr = addr_q;
  assign push_entry.data = rdata_b_i;

  rt_mem_rb_fifo u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (rd_valid_o && rd_ready_i),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // busy drops in the same cycle done pulses so the two never overlap.
  assign busy_o     = (state_q != ST_IDLE) && !done_o;
  assign error_o    = error_q;
  assign en_b_o     = (state_q == ST_REQ);
  assign we_b_o     = 1'b0;
  assign be_b_o     = 4'hF;
  assign addr_b_o   = addr_q;
  assign rd_valid_o = !fifo_empty;
  assign rd_data_o  = head.data;
  assign rd_addr_o  = head.addr;

endmodule
